// File: rtl/forwarding_unit.sv
// EX-stage operand forwarding control: compares ID-stage source registers against
// in-flight EX/MEM and MEM/WB destinations and registers the resulting mux selects.
module forwarding_unit #(
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] registerOP1ID,
    input  logic [REG_ADDR_W-1:0] registerOP2ID,
    input  logic [REG_ADDR_W-1:0] registerOP1EX,
    input  logic [REG_ADDR_W-1:0] registerOP1MEM,
    input  logic                  regWriteMEM,
    input  logic                  regWriteWB,
    output logic [1:0]            forwardA,
    output logic [1:0]            forwardB
);

    localparam logic [1:0] SEL_REGFILE = 2'b00;
    localparam logic [1:0] SEL_MEM_WB  = 2'b01;
    localparam logic [1:0] SEL_EX_MEM  = 2'b10;

    logic [1:0] next_a;
    logic [1:0] next_b;

    // EX/MEM wins over MEM/WB because it carries the younger write to the register.
    function automatic logic [1:0] pick_source(
        input logic [REG_ADDR_W-1:0] src,
        input logic [REG_ADDR_W-1:0] dst_ex,
        input logic [REG_ADDR_W-1:0] dst_mem,
        input logic                  wr_ex,
        input logic                  wr_mem
    );
        logic [1:0] sel;
        sel = SEL_REGFILE;
        if (wr_ex && (dst_ex == src)) begin
            sel = SEL_EX_MEM;
        end else if (wr_mem && (dst_mem == src)) begin
            sel = SEL_MEM_WB;
        end
        return sel;
    endfunction

    always_comb begin
        next_a = SEL_REGFILE;
        next_b = SEL_REGFILE;
        next_a = pick_source(registerOP1ID, registerOP1EX, registerOP1MEM,
                             regWriteMEM, regWriteWB);
        next_b = pick_source(registerOP2ID, registerOP1EX, registerOP1MEM,
                             regWriteMEM, regWriteWB);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            forwardA <= SEL_REGFILE;
            forwardB <= SEL_REGFILE;
        end else begin
            forwardA <= next_a;
            forwardB <= next_b;
        end
    end

endmodule

// File: tb/tb_forwarding_unit.sv
// Scoreboard bench for forwarding_unit: directed vectors push hand-computed selects,
// a monitor pops and compares one entry after each rising edge.
module tb_forwarding_unit;

    logic       clk;
    logic       rst_n;
    logic [3:0] registerOP1ID;
    logic [3:0] registerOP2ID;
    logic [3:0] registerOP1EX;
    logic [3:0] registerOP1MEM;
    logic       regWriteMEM;
    logic       regWriteWB;
    logic [1:0] forwardA;
    logic [1:0] forwardB;

    typedef struct {
        string      name;
        logic [1:0] exp_a;
        logic [1:0] exp_b;
    } expect_t;

    expect_t exp_q[$];
    int      vectors;
    int      miscompares;

    forwarding_unit #(.REG_ADDR_W(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .registerOP1ID  (registerOP1ID),
        .registerOP2ID  (registerOP2ID),
        .registerOP1EX  (registerOP1EX),
        .registerOP1MEM (registerOP1MEM),
        .regWriteMEM    (regWriteMEM),
        .regWriteWB     (regWriteWB),
        .forwardA       (forwardA),
        .forwardB       (forwardB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [1:0] exp_a,
                               input logic [1:0] exp_b);
        vectors++;
        if (forwardA !== exp_a || forwardB !== exp_b) begin
            miscompares++;
            $display("[TB] FAIL %s: got A=%b B=%b, expected A=%b B=%b",
                     name, forwardA, forwardB, exp_a, exp_b);
        end
    endtask

    // Inputs change on the falling edge; the expected selects appear after the next rise.
    task automatic applyStimulus(input string name,
                                 input logic [3:0] op1, input logic [3:0] op2,
                                 input logic [3:0] ex, input logic [3:0] mem,
                                 input logic wm, input logic ww,
                                 input logic [1:0] exp_a, input logic [1:0] exp_b);
        expect_t e;
        @(negedge clk);
        registerOP1ID  = op1;
        registerOP2ID  = op2;
        registerOP1EX  = ex;
        registerOP1MEM = mem;
        regWriteMEM    = wm;
        regWriteWB     = ww;
        e.name  = name;
        e.exp_a = exp_a;
        e.exp_b = exp_b;
        exp_q.push_back(e);
    endtask

    initial begin
        expect_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput(e.name, e.exp_a, e.exp_b);
            end
        end
    end

    initial begin
        expect_t e;
        int budget;
        vectors        = 0;
        miscompares    = 0;
        rst_n          = 1'b0;
        registerOP1ID  = '0;
        registerOP2ID  = '0;
        registerOP1EX  = '0;
        registerOP1MEM = '0;
        regWriteMEM    = 1'b0;
        regWriteWB     = 1'b0;

        #12;
        checkOutput("reset_state", 2'b00, 2'b00);

        @(negedge clk);
        rst_n   = 1'b1;
        e.name  = "reset_release_idle";
        e.exp_a = 2'b00;
        e.exp_b = 2'b00;
        exp_q.push_back(e);

        //            name              op1 op2  ex mem wm ww   A      B
        applyStimulus("no_match",        2,  5,  0,  3, 1, 1, 2'b00, 2'b00);
        applyStimulus("ex_to_a",         2,  5,  2,  3, 1, 1, 2'b10, 2'b00);
        applyStimulus("mem_to_b",        2,  5,  0,  5, 1, 1, 2'b00, 2'b01);
        applyStimulus("ex_priority_b",   2,  5,  5,  5, 1, 1, 2'b00, 2'b10);
        applyStimulus("wb_gated",        2,  5,  0,  5, 1, 0, 2'b00, 2'b00);
        applyStimulus("mem_gated",       2,  5,  5,  3, 0, 1, 2'b00, 2'b00);
        applyStimulus("both_ex",         7,  7,  7,  3, 1, 1, 2'b10, 2'b10);
        applyStimulus("reg0_mem_to_a",   0,  7,  4,  0, 1, 1, 2'b01, 2'b00);
        applyStimulus("split_stages",    3,  9,  3,  9, 1, 1, 2'b10, 2'b01);
        applyStimulus("top_regs",       15, 14, 15, 14, 1, 1, 2'b10, 2'b01);
        applyStimulus("msb_differs",     8,  1,  0,  9, 1, 1, 2'b00, 2'b00);
        applyStimulus("both_mem",        6,  6,  2,  6, 1, 1, 2'b01, 2'b01);
        applyStimulus("ex_priority_ab",  4,  4,  4,  4, 1, 1, 2'b10, 2'b10);
        applyStimulus("ex_off_falls_wb", 4,  4,  4,  4, 0, 1, 2'b01, 2'b01);
        applyStimulus("reg0_ex_to_b",    1,  0,  0,  0, 1, 0, 2'b00, 2'b10);
        applyStimulus("pre_reset",       7,  7,  7,  3, 1, 1, 2'b10, 2'b10);

        // Reset mid-cycle after the monitor has seen forwardA=10.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 2'b00, 2'b00);
        @(posedge clk);
        #1;
        checkOutput("reset_hold", 2'b00, 2'b00);

        @(negedge clk);
        rst_n   = 1'b1;
        e.name  = "reset_restore";
        e.exp_a = 2'b10;
        e.exp_b = 2'b10;
        exp_q.push_back(e);

        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        #2;
        if (exp_q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL drain: got %0d pending entries, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
